// File: rtl/cpm_reg_arb.sv
// Round-robin write/clear arbiter for a clear/enable register bank.
// A ClrAll pulse sweeps a one-hot clear across the whole bank.
module cpm_reg_arb #(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NREQ-1:0]      ReqVld,
    input  logic [NREQ-1:0]      ReqClr,
    input  logic [NREQ*AW-1:0]   ReqAddr,
    input  logic [NREQ*DW-1:0]   ReqData,
    output logic [NREQ-1:0]      ReqRdy,
    input  logic                 ClrAll,
    output logic [NREG-1:0]      RegEnable,
    output logic [NREG-1:0]      RegClear,
    output logic [DW-1:0]        RegDataIn,
    output logic                 Busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic            win_clr;
    logic            found;
    logic            addr_ok;
    logic            cnt_last;
    logic [NREG-1:0] addr_hot;
    logic [NREG-1:0] cnt_hot;
    int              idx;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            RegEnable <= '0;
            RegClear  <= '0;
            RegDataIn <= '0;
        end else begin
            state     <= state_nx;
            RegEnable <= '0;
            RegClear  <= '0;
            RegDataIn <= '0;
            if (state == SWEEP) begin
                RegClear <= cnt_hot;
                cnt      <= cnt_last ? '0 : cnt + 1'b1;
            end else if (ClrAll) begin
                cnt <= '0;
            end else if (found) begin
                rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (win_clr) begin
                    RegClear <= addr_hot;
                end else begin
                    RegEnable <= addr_hot;
                    RegDataIn <= addr_ok ? win_data : '0;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ClrAll) state_nx = SWEEP;
            SWEEP:   if (cnt_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        ReqRdy  = '0;
        if (state == IDLE && !ClrAll) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!found && ReqVld[PW'(idx)]) begin
                    found   = 1'b1;
                    gnt_idx = PW'(idx);
                end
            end
        end
        if (found) ReqRdy[gnt_idx] = 1'b1;
    end

    assign win_addr = ReqAddr[int'(gnt_idx)*AW +: AW];
    assign win_data = ReqData[int'(gnt_idx)*DW +: DW];
    assign win_clr  = ReqClr[gnt_idx];
    assign addr_ok  = 32'(win_addr) < 32'(NREG);
    assign addr_hot = addr_ok ? (NREG'(1) << win_addr) : '0;
    assign cnt_hot  = NREG'(1) << cnt;
    assign cnt_last = (32'(cnt) == 32'(NREG - 1));
    assign Busy     = (state == SWEEP);

endmodule

// File: tb/tb_cpm_reg_arb.sv
// Directed and random bench for cpm_reg_arb with a one-cycle output scoreboard.
// A second instance with a 4-bit address checks out-of-range requests.
module tb_cpm_reg_arb;

    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int AW   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NREQ-1:0]     vld;
    logic [NREQ-1:0]     op;
    logic [AW-1:0]       a [NREQ];
    logic [DW-1:0]       d [NREQ];
    logic                clr_all;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     rdy;
    logic [NREG-1:0]     en;
    logic [NREG-1:0]     rclr;
    logic [DW-1:0]       din;
    logic                busy;

    logic [NREQ-1:0]     vld2;
    logic [NREQ-1:0]     op2;
    logic [NREQ*4-1:0]   addr2;
    logic [NREQ*DW-1:0]  data2;
    logic [NREQ-1:0]     rdy2;
    logic [NREG-1:0]     en2;
    logic [NREG-1:0]     rclr2;
    logic [DW-1:0]       din2;
    logic                busy2;

    assign req_addr = {a[3], a[2], a[1], a[0]};
    assign req_data = {d[3], d[2], d[1], d[0]};

    cpm_reg_arb #(.DW(DW), .NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
        .Clk(clk), .Rst(rst), .ReqVld(vld), .ReqClr(op),
        .ReqAddr(req_addr), .ReqData(req_data), .ReqRdy(rdy),
        .ClrAll(clr_all), .RegEnable(en), .RegClear(rclr),
        .RegDataIn(din), .Busy(busy)
    );

    cpm_reg_arb #(.DW(DW), .NREQ(NREQ), .NREG(NREG), .AW(4)) dut2 (
        .Clk(clk), .Rst(rst), .ReqVld(vld2), .ReqClr(op2),
        .ReqAddr(addr2), .ReqData(data2), .ReqRdy(rdy2),
        .ClrAll(1'b0), .RegEnable(en2), .RegClear(rclr2),
        .RegDataIn(din2), .Busy(busy2)
    );

    typedef struct packed {
        logic [NREG-1:0] en;
        logic [NREG-1:0] clr;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   m_sweep;
    int   m_ptr;
    int   m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs, predict, then pop and compare.
    task automatic tick();
        logic [NREQ-1:0] er;
        exp_t e;
        int g;
        @(negedge clk);
        er = '0;
        g  = -1;
        if (!m_sweep && !clr_all) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && vld[i]) g = i;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("rdy", 32'(rdy), 32'(er));
        chk("busy", 32'(busy), 32'(m_sweep));
        e = '0;
        if (rst) begin
            m_sweep = 1'b0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_sweep) begin
            e.clr = NREG'(1) << m_cnt;
            if (m_cnt == NREG - 1) m_sweep = 1'b0;
            m_cnt = (m_cnt + 1) % NREG;
        end else if (clr_all) begin
            m_sweep = 1'b1;
            m_cnt   = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (op[g]) begin
                e.clr = NREG'(1) << a[g];
            end else begin
                e.en   = NREG'(1) << a[g];
                e.data = d[g];
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("en", 32'(en), 32'(e.en));
            chk("clr", 32'(rclr), 32'(e.clr));
            chk("data", 32'(din), 32'(e.data));
            chk("excl", 32'((|en) && (|rclr)), 32'd0);
        end
    endtask

    task automatic idle_inputs();
        vld     = '0;
        op      = '0;
        clr_all = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
    endtask

    initial begin
        rst   = 1'b1;
        vld2  = '0;
        op2   = '0;
        addr2 = '0;
        data2 = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_clr", 32'(rclr), 32'd0);
        chk("rst_data", 32'(din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        m_sweep = 1'b0;
        m_ptr   = 0;
        m_cnt   = 0;
        rst     = 1'b0;

        // Lone requester 2 writes 0xA5 to register 5.
        vld  = 4'b0100;
        a[2] = 3'd5;
        d[2] = 8'hA5;
        tick();
        chk("lone_en", 32'(en), 32'h20);
        chk("lone_data", 32'(din), 32'hA5);
        idle_inputs();
        tick();

        // Fresh reset, then all four valid: grants 0,1,2,3.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vld = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = 3'(i + 1);
            d[i] = 8'(8'h10 + i);
        end
        repeat (4) tick();
        idle_inputs();
        tick();

        // Bulk clear with requesters 1 and 3 pending; a second ClrAll mid-sweep.
        vld     = 4'b1010;
        a[1]    = 3'd6;
        d[1]    = 8'h61;
        a[3]    = 3'd7;
        d[3]    = 8'h73;
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        for (int s = 0; s < NREG; s++) begin
            clr_all = (s == 3);
            tick();
            chk("sweep_walk", 32'(rclr), 32'(NREG'(1) << s));
        end
        clr_all = 1'b0;
        tick();
        chk("after_sweep_en", 32'(en), 32'h40);
        vld = 4'b1000;
        tick();
        idle_inputs();
        tick();

        // Clear then write to the same register from requesters 0 and 1.
        vld  = 4'b0011;
        op   = 4'b0001;
        a[0] = 3'd3;
        a[1] = 3'd3;
        d[1] = 8'h5C;
        tick();
        chk("cw_clr", 32'(rclr), 32'h08);
        vld = 4'b0010;
        tick();
        chk("cw_en", 32'(en), 32'h08);
        chk("cw_data", 32'(din), 32'h5C);
        idle_inputs();
        tick();

        // Reset landing on the third sweep cycle.
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_sweep_busy", 32'(busy), 32'd0);
        rst  = 1'b0;
        vld  = 4'b0100;
        a[2] = 3'd1;
        d[2] = 8'h77;
        tick();
        idle_inputs();
        repeat (3) tick();

        // Out-of-range address on the wide-address instance.
        @(negedge clk);
        vld2  = 4'b0001;
        addr2 = 16'h0009;
        data2 = 32'h0000_0033;
        #1;
        chk("oor_rdy", 32'(rdy2), 32'h1);
        @(posedge clk);
        #1;
        chk("oor_en", 32'(en2), 32'd0);
        chk("oor_clr", 32'(rclr2), 32'd0);
        @(negedge clk);
        addr2 = 16'h0060;
        data2 = 32'h0000_4400;
        vld2  = 4'b0010;
        #1;
        chk("wide_rdy", 32'(rdy2), 32'h2);
        @(posedge clk);
        #1;
        chk("wide_en", 32'(en2), 32'h40);
        chk("wide_data", 32'(din2), 32'h44);
        vld2 = '0;

        // Random traffic with occasional bulk clears.
        for (int n = 0; n < 40; n++) begin
            vld     = 4'($urandom);
            op      = 4'($urandom);
            clr_all = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NREQ; i++) begin
                a[i] = 3'($urandom);
                d[i] = 8'($urandom);
            end
            tick();
        end
        idle_inputs();
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpm_reg_arb.md
CPM_REG_ARB -- requirements
Module: cpm_reg_arb

Parameters
REQ-001 DW, default 8, width of register data.
REQ-002 NREQ, default 4, number of requesters.
REQ-003 NREG, default 8, number of clear/enable registers in the managed bank.
REQ-004 AW, default 3, register address width, equal to clog2(NREG).

Interface
REQ-005 Clk  in  1  single clock; all logic is on its rising edge.
REQ-006 Rst  in  1  reset, synchronous and active-high.
REQ-007 ReqVld  in  NREQ  per-requester write/clear request valid.
REQ-008 ReqClr  in  NREQ  per-requester op: 1 = clear the addressed register, 0 = write data to it.
REQ-009 ReqAddr  in  NREQ*AW  per-requester target register; requester i occupies bits [i*AW +: AW].
REQ-010 ReqData  in  NREQ*DW  per-requester write data; requester i occupies bits [i*DW +: DW].
REQ-011 ReqRdy  out  NREQ  per-requester accept; a request is accepted when ReqVld[i] and ReqRdy[i] are both 1.
REQ-012 ClrAll  in  1  one-cycle pulse that starts a sequential clear of the whole bank.
REQ-013 RegEnable  out  NREG  one-hot load enable to the bank.
REQ-014 RegClear  out  NREG  one-hot clear to the bank.
REQ-015 RegDataIn  out  DW  data shared by all bank registers.
REQ-016 Busy  out  1  high while a bulk clear is in progress.

Function
REQ-017 The FSM SHALL have two states, IDLE and SWEEP, and SHALL enter IDLE on reset.
REQ-018 In IDLE, round-robin arbitration SHALL grant at most one valid requester per cycle: the first valid index at or after pointer rr_ptr, wrapping modulo NREQ.
REQ-019 ReqRdy SHALL be combinational: only the granted bit is high, and only in IDLE with ClrAll low; all bits are 0 otherwise.
REQ-020 On an accepted request, rr_ptr SHALL update to (granted index + 1) mod NREQ; with no acceptance, rr_ptr SHALL hold.
REQ-021 On an accepted write, the next cycle SHALL drive RegEnable bit ReqAddr high, RegClear all 0, and RegDataIn = ReqData of the winner; latency is 1 cycle.
REQ-022 On an accepted clear, the next cycle SHALL drive RegClear bit ReqAddr high, RegEnable all 0, and RegDataIn = 0.
REQ-023 RegEnable, RegClear and RegDataIn SHALL be registered and SHALL be single-cycle pulses; all are 0 in any cycle that follows no acceptance and no sweep step.
REQ-024 RegEnable and RegClear SHALL never be nonzero in the same cycle.
REQ-025 A request address >= NREG SHALL be accepted and consumed, with no bank output asserted for it.
REQ-026 ClrAll seen in IDLE SHALL move the FSM to SWEEP at the next edge, load sweep counter to 0, and block arbitration in that same cycle.
REQ-027 In SWEEP, each cycle SHALL register RegClear one-hot at the counter value and increment the counter.
REQ-028 After the step at counter NREG-1, the FSM SHALL return to IDLE; a sweep lasts exactly NREG cycles.
REQ-029 Busy SHALL be 1 exactly while in SWEEP, and ReqRdy SHALL be all 0 throughout SWEEP.
REQ-030 ClrAll asserted during SWEEP SHALL be ignored; the sweep is not restarted.
REQ-031 Pending requests SHALL hold ReqVld without loss during SWEEP and SHALL be arbitrated from the first IDLE cycle using the unchanged rr_ptr.

Reset
REQ-032 When Rst is high at an edge, the block SHALL set FSM = IDLE, rr_ptr = 0, sweep counter = 0, and RegEnable, RegClear, RegDataIn and Busy to 0.
REQ-033 Reset SHALL override everything, including mid-sweep: no further clear pulses, and ReqRdy SHALL reflect IDLE in the first cycle after reset.

Verification
REQ-034 Reset, then request 2 alone writing 0xA5 to addr 5 -> ReqRdy=4'b0100 in the same cycle; next cycle RegEnable=8'h20, RegDataIn=0xA5.
REQ-035 All four requesters valid for 4 cycles from reset -> grants in order 0,1,2,3, each winner's RegEnable pulse 1 cycle later.
REQ-036 ClrAll pulse with requesters 1 and 3 valid -> Busy high for 8 cycles, RegClear walks 0x01..0x80, ReqRdy=0 throughout, then requester 1 is granted first.
REQ-037 Requester 0 clears addr 3 while requester 1 writes addr 3 -> cycle t+1 RegClear=0x08; cycle t+2 RegEnable=0x08 with requester 1's data.
REQ-038 Rst asserted at the 3rd sweep cycle -> outputs 0 at the next edge, Busy=0, and no further RegClear pulses.
REQ-039 Write to addr 9 (with AW widened to 4) -> accepted, and no RegEnable or RegClear bit is set.
